md_divider_pipe: RTL and testbench
==================================

MD_DIVIDER_PIPE -- requirements
Module: md_divider_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 2, quotient bits resolved per BUSY cycle; legal values 1, 2, 4, 8, and XLEN mod BITS_PER_CYCLE = 0.
REQ-003 SHALL have parameter TAG_W, default 5, width of the sideband tag (destination register index).
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1: request present.
REQ-007 SHALL have port in_ready, output, 1: block can accept a request.
REQ-008 SHALL have port md_operation, input, 3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 SHALL have port alu_in1, input, XLEN: dividend (rs1).
REQ-010 SHALL have port alu_in2, input, XLEN: divisor (rs2).
REQ-011 SHALL have port in_tag, input, TAG_W: sideband, echoed unchanged on out_tag.
REQ-012 SHALL have port flush, input, 1: abort any in-flight or held operation.
REQ-013 SHALL have port out_valid, output, 1: out_result/out_tag valid.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-015 SHALL have port out_result, output, XLEN: quotient or remainder.
REQ-016 SHALL have port out_tag, output, TAG_W: tag of the completed request.
REQ-017 SHALL have port busy, output, 1: state is BUSY.

Function
REQ-018 SHALL implement states IDLE, BUSY, DONE; in_ready = (state == IDLE), combinational.
REQ-019 SHALL accept a request on a rising edge where state = IDLE, in_valid = 1, md_operation[2] = 1, and flush = 0; requests with md_operation[2] = 0 SHALL be ignored.
REQ-020 SHALL, on acceptance, register the dividend, the tag, and the operation; it SHALL take absolute values of both operands for DIV/REM and use them raw for DIVU/REMU.
REQ-021 SHALL, on acceptance with divisor = 0, go directly to DONE with result all-ones for DIV/DIVU and the original dividend for REM/REMU.
REQ-022 SHALL, on acceptance of DIV/REM with dividend = 2^(XLEN-1) and divisor = all-ones, go directly to DONE with result 2^(XLEN-1) for DIV and 0 for REM.
REQ-023 SHALL otherwise go to BUSY and perform restoring division MSB-first, BITS_PER_CYCLE bits per edge, for N = XLEN/BITS_PER_CYCLE edges; the remainder register SHALL be XLEN+1 bits wide so the compare does not overflow.
REQ-024 SHALL, on the Nth BUSY edge, go to DONE with the sign-corrected result registered into out_result.
REQ-025 SHALL negate the quotient for DIV when the operand signs differ, and negate the remainder for REM when the dividend is negative.
REQ-026 SHALL make out_valid high first N cycles after the acceptance edge in the normal path, and 1 cycle after the acceptance edge in the special-case paths.
REQ-027 SHALL assert out_valid only in DONE, and SHALL hold out_result and out_tag stable while out_valid = 1 and out_ready = 0.
REQ-028 SHALL go from DONE to IDLE on an edge with out_ready = 1; no new request is accepted on that same edge.
REQ-029 SHALL, when flush = 1, force the state to IDLE on the next edge from any state, discard the operation, and clear out_valid; flush SHALL take priority over in_valid and out_ready on the same edge.
REQ-030 SHALL keep out_result unchanged outside DONE, holding the last value.

Reset
REQ-031 SHALL, on an edge with reset_n = 0, set state to IDLE and set out_valid = 0, out_result = 0, out_tag = 0, busy = 0, and clear all internal registers.
REQ-032 SHALL take reset priority over flush and every handshake, including mid-BUSY, and SHALL produce no spurious out_valid afterward.

Verification (XLEN=32, BITS_PER_CYCLE=2, N=16)
REQ-033 DIV 0xFFFFFFF9 (-7) / 2, tag 3 with out_ready = 1 SHALL give out_valid exactly 16 cycles after acceptance, result 0xFFFFFFFD, out_tag 3; then REM with the same operands SHALL give 0xFFFFFFFF.
REQ-034 DIVU 100 / 0 SHALL give 0xFFFFFFFF one cycle after acceptance; REMU 100 / 0 SHALL give 100.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF SHALL give 0x80000000 in one cycle; REM with the same operands SHALL give 0.
REQ-036 DIVU 0xFFFFFFFF / 7 with out_ready = 0 for 5 cycles after out_valid SHALL give 0x24924924, held stable with in_ready = 0 throughout, and IDLE on the edge where out_ready = 1.
REQ-037 flush pulsed at BUSY cycle 6, with in_valid also high, SHALL return IDLE next cycle, give no out_valid, and leave that request unaccepted; a following request SHALL complete correctly.
REQ-038 reset_n low for one edge mid-BUSY SHALL give IDLE with out_result = 0, out_valid = 0, and no later completion.

Source files
------------

// File: rtl/md_divider_pipe.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU) with a tag sideband and
// valid/ready handshakes. Divide-by-zero and signed overflow finish immediately.
//
// state  | meaning
// IDLE   | waiting for a divide request, in_ready high
// BUSY   | resolving BITS_PER_CYCLE quotient bits per edge
// DONE   | result held on out_result/out_tag until out_ready

module md_divider_pipe #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 2,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       md_operation,
  input  logic [XLEN-1:0]  alu_in1,
  input  logic [XLEN-1:0]  alu_in2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t state, state_nx;

  logic             is_signed, op_rem, accept;
  logic             a_neg, b_neg, div_zero, ovf, special;
  logic [XLEN-1:0]  a_abs, b_abs, special_result;

  logic [XLEN:0]    rem_q;
  logic [XLEN-1:0]  quo_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rem_op_q, neg_q_q, neg_r_q;

  logic [XLEN:0]    r_step;
  logic [XLEN-1:0]  q_step, q_fin, r_fin;

  assign is_signed = ~md_operation[0];
  assign op_rem    = md_operation[1];
  assign accept    = (state == S_IDLE) & in_valid & md_operation[2] & ~flush;

  assign a_neg = is_signed & alu_in1[XLEN-1];
  assign b_neg = is_signed & alu_in2[XLEN-1];
  assign a_abs = a_neg ? -alu_in1 : alu_in1;
  assign b_abs = b_neg ? -alu_in2 : alu_in2;

  assign div_zero = (alu_in2 == '0);
  assign ovf      = is_signed & (alu_in1 == {1'b1, {(XLEN-1){1'b0}}}) & (&alu_in2);
  assign special  = div_zero | ovf;

  always_comb begin
    special_result = '0;
    if (div_zero)
      special_result = op_rem ? alu_in1 : '1;
    else
      special_result = op_rem ? '0 : alu_in1;
  end

  // One restoring step per resolved bit; remainder is XLEN+1 wide so the
  // shifted partial remainder never overflows the compare.
  always_comb begin
    r_step = rem_q;
    q_step = quo_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      r_step = {r_step[XLEN-1:0], q_step[XLEN-1]};
      q_step = {q_step[XLEN-2:0], 1'b0};
      if (r_step >= {1'b0, dvs_q}) begin
        r_step    = r_step - {1'b0, dvs_q};
        q_step[0] = 1'b1;
      end
    end
  end

  assign q_fin = neg_q_q ? -q_step : q_step;
  assign r_fin = neg_r_q ? -r_step[XLEN-1:0] : r_step[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = special ? S_DONE : S_BUSY;
      S_BUSY: if (cnt_q == CNT_W'(0)) state_nx = S_DONE;
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    busy      = (state == S_BUSY);
    out_valid = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      rem_op_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (accept) begin
      rem_q    <= '0;
      quo_q    <= a_abs;
      dvs_q    <= b_abs;
      cnt_q    <= CNT_W'(N - 1);
      rem_op_q <= op_rem;
      neg_q_q  <= a_neg ^ b_neg;
      neg_r_q  <= a_neg;
      out_tag  <= in_tag;
      if (special) out_result <= special_result;
    end else if (state == S_BUSY && !flush) begin
      rem_q <= r_step;
      quo_q <= q_step;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(0)) out_result <= rem_op_q ? r_fin : q_fin;
    end
  end

endmodule

// File: tb/tb_md_divider_pipe.sv
// Directed bench for md_divider_pipe: a vector table of divide cases plus
// hand-written backpressure, flush, ignored-op and mid-operation reset sequences.

module tb_md_divider_pipe;

  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [2:0]  md_operation;
  logic [31:0] alu_in1, alu_in2, out_result;
  logic [4:0]  in_tag, out_tag;

  int nvec = 0;
  int nmis = 0;

  md_divider_pipe #(.XLEN(32), .BITS_PER_CYCLE(2), .TAG_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .md_operation(md_operation), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .in_tag(in_tag), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // edges: posedges after the accepting edge until out_valid is seen
  // (0 means valid in the cycle right after acceptance).
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] res;
    int          edges;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    @(negedge clk);
    md_operation = op; alu_in1 = a; alu_in2 = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 64) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic quiet_cycles(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int e, seen;
    logic [31:0] held;

    vt.push_back('{DIV,  32'hFFFFFFF9, 32'd2,        5'd3,  32'hFFFFFFFD, 16});
    vt.push_back('{REM,  32'hFFFFFFF9, 32'd2,        5'd3,  32'hFFFFFFFF, 16});
    vt.push_back('{DIVU, 32'd100,      32'd0,        5'd1,  32'hFFFFFFFF, 0});
    vt.push_back('{REMU, 32'd100,      32'd0,        5'd2,  32'd100,      0});
    vt.push_back('{DIV,  32'h80000000, 32'hFFFFFFFF, 5'd4,  32'h80000000, 0});
    vt.push_back('{REM,  32'h80000000, 32'hFFFFFFFF, 5'd5,  32'h00000000, 0});
    vt.push_back('{DIVU, 32'd1000,     32'd7,        5'd6,  32'd142,      16});
    vt.push_back('{REMU, 32'd1000,     32'd7,        5'd7,  32'd6,        16});
    vt.push_back('{DIV,  32'd100,      32'hFFFFFFF9, 5'd8,  32'hFFFFFFF2, 16});
    vt.push_back('{REM,  32'd100,      32'hFFFFFFF9, 5'd9,  32'd2,        16});
    vt.push_back('{DIV,  32'hFFFFFF9C, 32'hFFFFFFF9, 5'd10, 32'd14,       16});
    vt.push_back('{REM,  32'hFFFFFF9C, 32'hFFFFFFF9, 5'd11, 32'hFFFFFFFE, 16});
    vt.push_back('{DIVU, 32'hFFFFFFFF, 32'd1,        5'd12, 32'hFFFFFFFF, 16});
    vt.push_back('{DIV,  32'h80000000, 32'd1,        5'd13, 32'h80000000, 16});
    vt.push_back('{DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        16});
    vt.push_back('{REMU, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 16});
    vt.push_back('{REMU, 32'd7,        32'd16,       5'd31, 32'd7,        16});

    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    md_operation = 3'b000; alu_in1 = '0; alu_in2 = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check("reset out_valid", out_valid, 0);
    check("reset out_result", out_result, 0);
    check("reset out_tag", out_tag, 0);
    check("reset in_ready", in_ready, 1);
    check("reset busy", busy, 0);

    foreach (vt[i]) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].tag);
      if (vt[i].edges > 0) check($sformatf("v%0d busy", i), busy, 1);
      wait_valid(e);
      check($sformatf("v%0d latency", i), e, vt[i].edges);
      check($sformatf("v%0d result", i), out_result, vt[i].res);
      check($sformatf("v%0d tag", i), out_tag, vt[i].tag);
      check($sformatf("v%0d in_ready in DONE", i), in_ready, 0);
      @(posedge clk); #1;
      check($sformatf("v%0d back to idle", i), in_ready, 1);
    end

    // Non-divide opcode is ignored.
    @(negedge clk);
    md_operation = 3'b001; alu_in1 = 32'd9; alu_in2 = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ignored op busy", busy, 0);
    check("ignored op out_valid", out_valid, 0);
    check("ignored op in_ready", in_ready, 1);

    // Backpressure: result held while out_ready low, no accept on release edge.
    out_ready = 1'b0;
    issue(DIVU, 32'hFFFFFFFF, 32'd7, 5'd4);
    wait_valid(e);
    check("bp latency", e, 16);
    check("bp result", out_result, 32'h24924924);
    held = out_result;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      md_operation = REMU; alu_in1 = 32'd5; alu_in2 = 32'd0; in_tag = 5'd20; in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("bp hold valid %0d", k), out_valid, 1);
      check($sformatf("bp hold result %0d", k), out_result, held);
      check($sformatf("bp hold tag %0d", k), out_tag, 5'd4);
      check($sformatf("bp hold in_ready %0d", k), in_ready, 0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp release in_ready", in_ready, 1);
    check("bp release out_valid", out_valid, 0);
    check("bp release busy", busy, 0);

    // Flush at BUSY cycle 6 with a competing request.
    issue(DIVU, 32'hFFFFFFFF, 32'd7, 5'd2);
    repeat (5) begin @(posedge clk); #1; end
    check("flush pre busy", busy, 1);
    @(negedge clk);
    flush = 1'b1; md_operation = DIV; alu_in1 = 32'd50; alu_in2 = 32'd5; in_tag = 5'd17; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush in_ready", in_ready, 1);
    check("flush busy", busy, 0);
    check("flush out_valid", out_valid, 0);
    quiet_cycles(24, seen);
    check("flush no completion", seen, 0);
    issue(DIVU, 32'd1000, 32'd7, 5'd9);
    wait_valid(e);
    check("post flush latency", e, 16);
    check("post flush result", out_result, 32'd142);
    check("post flush tag", out_tag, 5'd9);
    @(posedge clk); #1;

    // Reset mid-BUSY.
    issue(DIV, 32'd1000, 32'd3, 5'd7);
    repeat (4) begin @(posedge clk); #1; end
    check("rst pre busy", busy, 1);
    @(negedge clk) reset_n = 1'b0;
    @(posedge clk); #1;
    check("rst in_ready", in_ready, 1);
    check("rst out_result", out_result, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_tag", out_tag, 0);
    check("rst busy", busy, 0);
    @(negedge clk) reset_n = 1'b1;
    quiet_cycles(24, seen);
    check("rst no completion", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
